// File: rtl/idct_pkg.sv
// idct_pkg: shared constants, FSM states and cosine-table helper for the 8x8 Chen IDCT.
package idct_pkg;
    localparam int WORDS     = 64;
    localparam int Q_SHIFT   = 30;
    localparam int ROUND_ADD = 1 << (Q_SHIFT - 1);
    localparam int FRAC_W    = 16;
    localparam int PIX_HALF  = 1 << (FRAC_W - 1);
    localparam int PIX_MAX   = 127;
    localparam int PIX_MIN   = -128;
    // Index 0 is C(0)/2 = 1/(2*sqrt2); index m>0 is cos(m*pi/16)/2, all Q2.30
    localparam logic signed [31:0] COS_Q [8] = '{
        32'sd379625062, 32'sd526555088, 32'sd496004047, 32'sd446391849,
        32'sd379625062, 32'sd298269498, 32'sd205451603, 32'sd104738319
    };

    typedef enum logic [1:0] {IDLE, ROW, COL} state_t;

    function automatic logic signed [31:0] coef_q(input int k, input int n);
        int m;
        logic neg;
        if (k == 0) return COS_Q[0];
        m = ((2 * n + 1) * k) % 32;
        neg = 1'b0;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
            m = 16 - m;
            neg = 1'b1;
        end
        return neg ? -COS_Q[m] : COS_Q[m];
    endfunction
endpackage

// File: rtl/idct1d_8pt.sv
// idct1d_8pt: combinational 8-point IDCT; Q2.30 constants, half-up rounding, saturation to OUT_W.
module idct1d_8pt
    import idct_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int COEF_W = 32,
    parameter int OUT_W  = 32
) (
    input  logic signed [IN_W-1:0]  d_i [8],
    output logic signed [OUT_W-1:0] q_o [8]
);
    localparam int ACC_W = IN_W + COEF_W + 3;
    localparam logic signed [ACC_W-1:0] HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] LO = ~HI;

    for (genvar n = 0; n < 8; n++) begin : g_out
        logic signed [ACC_W-1:0] p [8];
        logic signed [ACC_W-1:0] acc, sh;
        for (genvar k = 0; k < 8; k++) begin : g_term
            localparam logic signed [COEF_W-1:0] C = COEF_W'(coef_q(k, n));
            assign p[k] = ACC_W'(d_i[k]) * ACC_W'(C);
        end
        always_comb begin
            acc = ACC_W'(ROUND_ADD);
            for (int i = 0; i < 8; i++) acc = acc + p[i];
            sh = acc >>> Q_SHIFT;
        end
        assign q_o[n] = sh > HI ? HI[OUT_W-1:0] : sh < LO ? LO[OUT_W-1:0] : sh[OUT_W-1:0];
    end
endmodule

// File: rtl/idct2d_8x8_chen.sv
// idct2d_8x8_chen: 8x8 inverse DCT, row pass -> transpose -> column pass on one shared 1-D datapath.
// Define IDCT_PIXEL_CLAMP_EN to round column results to integers clamped to [-128, 127].
module idct2d_8x8_chen
    import idct_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int COEF_W = 32,
    parameter int OUT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W*WORDS-1:0] x,
    output logic                    busy,
    output logic                    valid_out,
    output logic [OUT_W*WORDS-1:0]  y
);
    localparam int MID_W = DATA_W > OUT_W ? DATA_W : OUT_W;
    localparam logic signed [MID_W-1:0] D_HI = {{(MID_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [MID_W-1:0] D_LO = ~D_HI;
    localparam logic signed [MID_W-1:0] O_HI = {{(MID_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [MID_W-1:0] O_LO = ~O_HI;

    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic valid_q;
    logic signed [DATA_W-1:0] in_q [8][8];
    logic signed [DATA_W-1:0] tr_q [8][8];
    logic signed [OUT_W-1:0]  y_q  [8][8];
    logic signed [DATA_W-1:0] dp_in   [8];
    logic signed [MID_W-1:0]  dp_out  [8];
    logic signed [DATA_W-1:0] row_res [8];
    logic signed [OUT_W-1:0]  col_sat [8];
    logic signed [OUT_W-1:0]  col_res [8];
`ifdef IDCT_PIXEL_CLAMP_EN
    logic signed [OUT_W:0]    pix     [8];
`endif

    always_comb begin
        state_d = state_q == IDLE ? (start ? ROW : IDLE)
                : cnt_q != 3'd7 ? state_q
                : state_q == ROW ? COL : IDLE;
        cnt_d = state_q == IDLE ? 3'd0 : cnt_q + 3'd1;
    end

    // Row pass reads the input buffer, column pass reads the transpose buffer
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            dp_in[i]   = state_q == COL ? tr_q[cnt_q][i] : in_q[cnt_q][i];
            row_res[i] = dp_out[i] > D_HI ? D_HI[DATA_W-1:0] : dp_out[i] < D_LO ? D_LO[DATA_W-1:0] : dp_out[i][DATA_W-1:0];
            col_sat[i] = dp_out[i] > O_HI ? O_HI[OUT_W-1:0] : dp_out[i] < O_LO ? O_LO[OUT_W-1:0] : dp_out[i][OUT_W-1:0];
`ifdef IDCT_PIXEL_CLAMP_EN
            pix[i]     = ((OUT_W+1)'(col_sat[i]) + (OUT_W+1)'(PIX_HALF)) >>> FRAC_W;
            col_res[i] = pix[i] > (OUT_W+1)'(PIX_MAX) ? OUT_W'(PIX_MAX <<< FRAC_W)
                       : pix[i] < (OUT_W+1)'(PIX_MIN) ? OUT_W'(PIX_MIN <<< FRAC_W)
                       : OUT_W'(pix[i] <<< FRAC_W);
`else
            col_res[i] = col_sat[i];
`endif
        end
    end

    idct1d_8pt #(.IN_W(DATA_W), .COEF_W(COEF_W), .OUT_W(MID_W)) u_dp (
        .d_i(dp_in),
        .q_o(dp_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
            y_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= state_q == COL && cnt_q == 3'd7;
            if (state_q == IDLE && start)
                for (int i = 0; i < 8; i++)
                    for (int j = 0; j < 8; j++)
                        in_q[i][j] <= x[(8*i+j)*DATA_W +: DATA_W];
            if (state_q == ROW)
                for (int n = 0; n < 8; n++) tr_q[n][cnt_q] <= row_res[n];
            if (state_q == COL)
                for (int n = 0; n < 8; n++) y_q[n][cnt_q] <= col_res[n];
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_row
        for (genvar j = 0; j < 8; j++) begin : g_col
            assign y[(8*i+j)*OUT_W +: OUT_W] = y_q[i][j];
        end
    end

    assign busy      = state_q != IDLE;
    assign valid_out = valid_q;
endmodule

// File: tb/tb_idct2d_8x8_chen.sv
// tb_idct2d_8x8_chen: scoreboard bench; expected blocks come from a real-valued DCT model.
module tb_idct2d_8x8_chen;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2047:0] x = '0;
    logic busy, valid_out;
    logic [2047:0] y;
    int total = 0, bad = 0;

    typedef struct { logic [2047:0] y; int tol; } exp_t;
    exp_t exp_q [$];
    real a_tab [8][8];
`ifdef IDCT_PIXEL_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    localparam int RT_TOL = CLAMP ? 32'h8000 : 16;

    idct2d_8x8_chen dut (
        .clk(clk), .rst(rst), .start(start), .x(x),
        .busy(busy), .valid_out(valid_out), .y(y)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cycle(input logic s, input logic [2047:0] blk);
        start = s;
        x = blk;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [2047:0] fwd(input logic [2047:0] s);
        real sp [8][8];
        real t [8][8];
        real acc;
        logic signed [31:0] w;
        logic [2047:0] r;
        for (int i = 0; i < 64; i++) sp[i/8][i%8] = $itor($signed(s[i*32 +: 32])) / 65536.0;
        for (int u = 0; u < 8; u++)
            for (int m = 0; m < 8; m++) begin
                t[u][m] = 0.0;
                for (int n = 0; n < 8; n++) t[u][m] += a_tab[u][n] * sp[n][m];
            end
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++) begin
                acc = 0.0;
                for (int m = 0; m < 8; m++) acc += t[u][m] * a_tab[v][m];
                w = acc >= 0.0 ? $rtoi(acc * 65536.0 + 0.5) : -$rtoi(-acc * 65536.0 + 0.5);
                r[(8*u+v)*32 +: 32] = w;
            end
        return r;
    endfunction

    function automatic logic [2047:0] rand_spatial();
        logic [2047:0] r;
        for (int i = 0; i < 64; i++)
            r[i*32 +: 32] = CLAMP ? ($urandom_range(0, 255) - 128) << 16
                                  : $urandom_range(0, 32'h00FF_FFFF) - 32'h0080_0000;
        return r;
    endfunction

    function automatic int first_bad(input logic [2047:0] a, input logic [2047:0] e, input int tol);
        longint d;
        for (int i = 0; i < 64; i++) begin
            d = longint'($signed(a[i*32 +: 32])) - longint'($signed(e[i*32 +: 32]));
            if (d > tol || d < -tol) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b1, {64{32'h1234_5678}});
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        total++; if (y !== '0) begin bad++; $display("FAIL reset_y: got %h want 0", y[63:0]); end
        rst = 1'b0;
        cycle(1'b0, '0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_vs_start: busy got %b want 0", busy); end
    endtask

    task automatic test_zero();
        exp_t e;
        int nbusy = 0, nvalid = 0, vat = -1, bi;
        e.y = '0; e.tol = 0;
        exp_q.push_back(e);
        for (int k = 0; k <= 20; k++) begin
            cycle(k == 0, '0);
            if (busy === 1'b1) nbusy++;
            if (valid_out === 1'b1) begin
                nvalid++; vat = k;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL zero_block: got unexpected valid want none"); end
                else begin
                    e = exp_q.pop_front();
                    bi = first_bad(y, e.y, e.tol);
                    if (bi !== -1) begin bad++; $display("FAIL zero_block: word %0d got %h want %h", bi, y[bi*32 +: 32], e.y[bi*32 +: 32]); end
                end
            end
        end
        total++; if (nvalid !== 1 || vat !== 16) begin bad++; $display("FAIL zero_valid_timing: got %0d pulses last after edge %0d want 1 after edge 16", nvalid, vat); end
        total++; if (nbusy !== 16) begin bad++; $display("FAIL zero_busy_cycles: got %0d want 16", nbusy); end
        exp_q.delete();
    endtask

    task automatic test_dc();
        logic [2047:0] blk;
        exp_t e;
        int lat = -1, bi;
        blk = '0;
        blk[31:0] = 32'h0008_0000;
        e.y = {64{32'h0001_0000}}; e.tol = 1;
        exp_q.push_back(e);
        cycle(1'b1, blk);
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            cycle(1'b0, blk);
            if (valid_out === 1'b1) lat = k;
        end
        total++; if (lat !== 16) begin bad++; $display("FAIL dc_latency: got valid after edge %0d want 16", lat); end
        if (lat >= 0) begin
            e = exp_q.pop_front();
            bi = first_bad(y, e.y, e.tol);
            total++; if (bi !== -1) begin bad++; $display("FAIL dc_block: word %0d got %h want %h", bi, y[bi*32 +: 32], e.y[bi*32 +: 32]); end
        end
        exp_q.delete();
    endtask

    task automatic test_clamp_2048();
        logic [2047:0] blk;
        exp_t e;
        int lat = -1, bi;
        blk = '0;
        blk[31:0] = 32'h0800_0000;
        e.y = CLAMP ? {64{32'h007F_0000}} : {64{32'h0100_0000}}; e.tol = 0;
        exp_q.push_back(e);
        cycle(1'b1, blk);
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            cycle(1'b0, blk);
            if (valid_out === 1'b1) lat = k;
        end
        total++; if (lat !== 16) begin bad++; $display("FAIL big_dc_latency: got valid after edge %0d want 16", lat); end
        if (lat >= 0) begin
            e = exp_q.pop_front();
            bi = first_bad(y, e.y, e.tol);
            total++; if (bi !== -1) begin bad++; $display("FAIL big_dc_block: word %0d got %h want %h", bi, y[bi*32 +: 32], e.y[bi*32 +: 32]); end
        end
        exp_q.delete();
    endtask

    task automatic test_round_trip();
        logic [2047:0] orig, coefs;
        exp_t e;
        int lat, bi;
        for (int b = 0; b < 100; b++) begin
            orig = rand_spatial();
            coefs = fwd(orig);
            e.y = orig; e.tol = RT_TOL;
            exp_q.push_back(e);
            cycle(1'b1, coefs);
            lat = -1;
            for (int k = 1; k <= 40 && lat < 0; k++) begin
                cycle(1'b0, coefs);
                if (valid_out === 1'b1) lat = k;
            end
            total++;
            if (lat < 0) begin
                bad++; $display("FAIL round_trip_timeout: block %0d got no valid want valid", b);
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            bi = first_bad(y, e.y, e.tol);
            if (bi !== -1) begin bad++; $display("FAIL round_trip: block %0d word %0d got %h want %h", b, bi, y[bi*32 +: 32], e.y[bi*32 +: 32]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2047:0] s1, s3, c1, c2, c3;
        exp_t e;
        int vk [$];
        int bi;
        s1 = rand_spatial(); s3 = rand_spatial();
        c1 = fwd(s1); c2 = fwd(rand_spatial()); c3 = fwd(s3);
        for (int k = 0; k <= 40; k++) begin
            if (k == 0) begin e.y = s1; e.tol = RT_TOL; exp_q.push_back(e); end
            if (k == 17) begin e.y = s3; e.tol = RT_TOL; exp_q.push_back(e); end
            cycle(k == 0 || k == 5 || k == 17, k == 5 ? c2 : k >= 17 ? c3 : c1);
            if (valid_out === 1'b1) begin
                vk.push_back(k);
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_block: got unexpected valid after edge %0d want none", k); end
                else begin
                    e = exp_q.pop_front();
                    bi = first_bad(y, e.y, e.tol);
                    if (bi !== -1) begin bad++; $display("FAIL b2b_block: after edge %0d word %0d got %h want %h", k, bi, y[bi*32 +: 32], e.y[bi*32 +: 32]); end
                end
            end
        end
        total++;
        if (vk.size() != 2 || vk[0] != 16 || vk[1] != 33) begin
            bad++; $display("FAIL b2b_timing: got %0d valids first after edge %0d want 2 after edges 16 and 33", vk.size(), vk.size() > 0 ? vk[0] : -1);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [2047:0] c;
        int nvalid = 0, nbusy = 0;
        c = fwd(rand_spatial());
        for (int k = 0; k <= 40; k++) begin
            rst = k == 5;
            cycle(k == 0, c);
            if (valid_out === 1'b1) nvalid++;
            if (k >= 5 && busy !== 1'b0) nbusy++;
            if (k == 5) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
                total++; if (y !== '0) begin bad++; $display("FAIL mid_reset_y: got %h want 0", y[63:0]); end
            end
        end
        rst = 1'b0;
        total++; if (nvalid !== 0) begin bad++; $display("FAIL mid_reset_valid: got %0d pulses want 0", nvalid); end
        total++; if (nbusy !== 0) begin bad++; $display("FAIL mid_reset_busy_after: got %0d busy cycles want 0", nbusy); end
    endtask

    initial begin
        for (int u = 0; u < 8; u++)
            for (int n = 0; n < 8; n++)
                a_tab[u][n] = (u == 0 ? 0.5 / $sqrt(2.0) : 0.5) * $cos((2 * n + 1) * u * 3.141592653589793 / 16.0);
        test_reset();
        test_zero();
        test_dc();
        test_clamp_2048();
        test_round_trip();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/idct2d_8x8_chen.md
# idct2d_8x8_chen

Inverse 2‑D 8×8 DCT core, the decode‑side counterpart of `dct2d_8x8_chen`. It accepts one block of 64 Q16.16 DCT coefficients as a packed vector. It runs a row pass, an internal transpose and a column pass through one shared 8‑point 1‑D IDCT datapath, then presents 64 reconstructed Q16.16 samples. The core sits after dequantisation in the decompression path and shares the packed‑vector start/valid_out convention of the forward core.

## Interface
- `DATA_W`, 32: input and intermediate word width, Q16.16 signed.
- `COEF_W`, 32: cosine constant width, Q2.30 signed.
- `OUT_W`, 32: output word width, Q16.16 signed.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset is synchronous and active‑high.
- `start` in 1: one‑cycle request; `x` is captured on the same edge.
- `x` in `DATA_W*64`: coefficients, row‑major, word i at `[i*DATA_W +: DATA_W]`, i = 8·u + v.
- `busy` out 1: high while a block is in flight.
- `valid_out` out 1: one‑cycle pulse when `y` is updated.
- `y` out `OUT_W*64`: reconstructed samples, row‑major, same packing as `x`.

## Operation
- FSM states: IDLE, ROW, COL.
- IDLE: if `start`=1, capture `x` into the input buffer, clear the pass counter and go to ROW. Otherwise hold.
- ROW: for each cycle r = 0..7, input row r goes through `idct1d_8pt`. The result is written as column r of the transpose buffer. At r = 7, go to COL.
- COL: for each cycle c = 0..7, transpose‑buffer row c goes through `idct1d_8pt`. The result is written as column c of the `y` register. At c = 7, pulse `valid_out` and go to IDLE.
- 1‑D transform: x[n] = Σ_k (C(k)/2)·X[k]·cos((2n+1)kπ/16), with C(0) = 1/√2 and C(k>0) = 1. This is the orthonormal inverse of the forward core.
- Arithmetic: DATA_W × COEF_W products are summed over 8 terms in a DATA_W+COEF_W+3 accumulator. Each sum is rounded half‑up (add 2^29), arithmetically shifted right by 30, and saturated to DATA_W (row pass) or OUT_W (column pass).
- `start` while `busy`=1 is ignored. The in‑flight block is unaffected.
- `y` holds its value until the next completed block. `x` may change freely after the capture edge.
- Reset: state goes to IDLE; `busy`=0, `valid_out`=0, `y`=0. Buffers need not be cleared.
- Reset mid‑block aborts the block: no `valid_out`, and `y` reads 0.

## Timing
- Label the capture edge T0. Row results are written at T1..T8 and column results at T9..T16.
- `valid_out` is high in the cycle after T16, i.e. it is sampled high at T17. Latency from `start` to `valid_out` is 17 edges.
- `busy` rises after T0 and falls after T16.
- Back‑to‑back: a `start` sampled at T17 (while `valid_out` is high) is accepted. Throughput is 1 block per 17 cycles.
- `start` and `rst` high on the same edge: reset wins and the block is not captured.

## Configuration
- `IDCT_PIXEL_CLAMP_EN` defined: each column‑pass result is rounded to the nearest integer (half‑up) and clamped to [−128.0, +127.0], i.e. 0xFF80_0000..0x007F_0000. The output is ready for +128 level shift.
- Not defined: raw Q16.16 column‑pass results, saturated only to `OUT_W`.
- Latency and handshake are identical in both builds.

## Structure
- Package `idct_pkg`:
  - the 8 cosine constants C(k)/2·cos(mπ/16) in Q2.30;
  - Q‑format shift and rounding constants;
  - the FSM state enum;
  - the words‑per‑block constant (64).
- Sub‑module `idct1d_8pt`: combinational 8‑in/8‑out 1‑D IDCT with rounding and saturation, parameterised by input/output width. It is instantiated once and shared by both passes.
- The top level holds the FSM, pass counter, input buffer, transpose buffer and output register.

## Test plan
- All‑zero block, `start` at T0: `valid_out` sampled high only at T17; all 64 `y` words = 0x0000_0000; `busy` high for exactly 16 cycles.
- DC only, X[0][0] = 0x0008_0000 (8.0), rest 0: all 64 `y` words = 0x0001_0000 (1.0), within ±1 LSB.
- Round trip: forward‑core expected outputs for 100 blocks as input: each `y` word within ±0x8000 of the original forward input word.
- Busy/back‑to‑back:
  - `start` pulses at T0, T5 and T17 with distinct blocks.
  - The T5 pulse is ignored.
  - `valid_out` occurs at T17 and T34, carrying the results of blocks 1 and 3.
- Reset mid‑block: `start` at T0, `rst` at T5: no `valid_out` through T40; `y` = 0 and `busy` = 0 after T5.
- X[0][0] = 0x0800_0000 (2048.0):
  - with `IDCT_PIXEL_CLAMP_EN` defined, all `y` words = 0x007F_0000;
  - without it, all `y` words = 0x0100_0000.
